uart_rx: RTL and testbench

//  Serial UART receiver, the stage directly upstream of the RX FIFO controller.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame geometry
// common to the receiver, transmitter and baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DBIT       = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_SB_TICK    = 16;

    function automatic int uart_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the serial input plus a start-edge detector.
// The edge reference only advances on s_tick so a fall is held until the FSM sees it.
module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic s_tick,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            if (s_tick) begin
                prev_q <= sync_q;
            end
        end
    end

    assign rx_s = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DBIT data bits LSB first, optional parity,
// stop period. Word and status are registered together with the done pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int SB_TICK    = UART_SB_TICK,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int SW = $clog2(uart_max(SB_TICK, OVERSAMPLE));
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);

    logic rx_s;
    logic fall;

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            done_q, done_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;

    uart_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .rx     (rx),
        .rx_s   (rx_s),
        .fall   (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        if (s_tick) begin
            case (state_q)
                ST_IDLE: begin
                    // Requires a real 1->0 transition; a line held low never re-triggers.
                    if (fall) begin
                        state_d = ST_START;
                        s_d     = '0;
                    end
                end
                ST_START: begin
                    if (s_q == S_HALF) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (s_q == S_BIT) begin
                        par_d   = ((^b_q) ^ rx_s) != ODD;
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (s_q == S_STOP) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        perr_d  = (PARITY_EN != 0) ? par_q : 1'b0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;
    assign parity_err   = perr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance, s_tick every 4 clk.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_p   = 1'b1;

    logic       done_a, ferr_a, perr_a, busy_a;
    logic [7:0] dout_a;
    logic       done_b, ferr_b, perr_b, busy_b;
    logic [7:0] dout_b;

    int         checks = 0;
    int         errors = 0;
    int         cnt_a  = 0;
    int         cnt_b  = 0;
    logic       tick_seen = 1'b0;
    logic       pd_a = 1'b0;
    logic       pd_b = 1'b0;
    logic [7:0] q_a[$];

    uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
        .rx_done_tick(done_a), .dout(dout_a), .frame_err(ferr_a),
        .parity_err(perr_a), .busy(busy_a)
    );

    uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
        .rx_done_tick(done_b), .dout(dout_b), .frame_err(ferr_b),
        .parity_err(perr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(posedge clk) tick_seen <= s_tick;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        pd_a <= done_a;
        pd_b <= done_b;
        if (done_a) begin
            check_eq("a_width", {31'd0, pd_a}, 32'd0);
            check_eq("a_latency", {31'd0, tick_seen}, 32'd1);
            check_eq("a_busy_at_done", {31'd0, busy_a}, 32'd0);
            check_eq("a_parity_err", {31'd0, perr_a}, 32'd0);
            cnt_a <= cnt_a + 1;
            q_a.push_back(dout_a);
            $display("[%0t] rx 8N1 dout=%02h frame_err=%b parity_err=%b", $time, dout_a, ferr_a, perr_a);
        end
        if (done_b) begin
            check_eq("b_width", {31'd0, pd_b}, 32'd0);
            check_eq("b_latency", {31'd0, tick_seen}, 32'd1);
            cnt_b <= cnt_b + 1;
            $display("[%0t] rx 8E1 dout=%02h frame_err=%b parity_err=%b", $time, dout_b, ferr_b, perr_b);
        end
    end

    task automatic send_bit(input bit on_p, input logic v);
        if (on_p) rx_p = v;
        else      rx   = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit on_p, input bit has_par,
                              input logic par_bit, input logic stop_bit, input int gap);
        send_bit(on_p, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(on_p, d[i]);
        if (has_par) send_bit(on_p, par_bit);
        send_bit(on_p, stop_bit);
        for (int i = 0; i < gap; i++) send_bit(on_p, 1'b1);
    endtask

    initial begin
        logic [7:0] c3;
        c3 = 8'hC3;

        repeat (3) @(negedge clk);
        check_eq("rst_dout", {24'd0, dout_a}, 32'h0);
        check_eq("rst_done", {31'd0, done_a}, 32'h0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'h0);
        check_eq("rst_ferr", {31'd0, ferr_a}, 32'h0);
        check_eq("rst_perr_b", {31'd0, perr_b}, 32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // nominal frame
        send_frame(8'hA5, 0, 0, 1'b0, 1'b1, 2);
        check_eq("t1_count", cnt_a, 1);
        check_eq("t1_dout", {24'd0, dout_a}, 32'hA5);
        check_eq("t1_ferr", {31'd0, ferr_a}, 32'h0);
        check_eq("t1_busy", {31'd0, busy_a}, 32'h0);

        // two-tick glitch: false start
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("t2_busy_high", {31'd0, busy_a}, 32'h1);
        repeat (48) @(negedge clk);
        check_eq("t2_busy_low", {31'd0, busy_a}, 32'h0);
        check_eq("t2_count", cnt_a, 1);
        check_eq("t2_dout", {24'd0, dout_a}, 32'hA5);

        // framing error then recovery
        send_frame(8'h3C, 0, 0, 1'b0, 1'b0, 2);
        check_eq("t3_count", cnt_a, 2);
        check_eq("t3_dout", {24'd0, dout_a}, 32'h3C);
        check_eq("t3_ferr", {31'd0, ferr_a}, 32'h1);
        send_frame(8'h55, 0, 0, 1'b0, 1'b1, 2);
        check_eq("t3b_count", cnt_a, 3);
        check_eq("t3b_dout", {24'd0, dout_a}, 32'h55);
        check_eq("t3b_ferr", {31'd0, ferr_a}, 32'h0);

        // even parity: 0x07 has three ones, correct parity bit is 1
        send_frame(8'h07, 1, 1, 1'b1, 1'b1, 2);
        check_eq("t4_count", cnt_b, 1);
        check_eq("t4_dout", {24'd0, dout_b}, 32'h07);
        check_eq("t4_perr_ok", {31'd0, perr_b}, 32'h0);
        check_eq("t4_ferr", {31'd0, ferr_b}, 32'h0);
        send_frame(8'h07, 1, 1, 1'b0, 1'b1, 2);
        check_eq("t4b_count", cnt_b, 2);
        check_eq("t4b_perr_bad", {31'd0, perr_b}, 32'h1);

        // back-to-back frames with no idle gap
        q_a.delete();
        send_frame(8'h00, 0, 0, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 0, 0, 1'b0, 1'b1, 0);
        send_frame(8'h81, 0, 0, 1'b0, 1'b1, 2);
        check_eq("t5_count", cnt_a, 6);
        check_eq("t5_qsize", q_a.size(), 3);
        if (q_a.size() == 3) begin
            check_eq("t5_first", {24'd0, q_a[0]}, 32'h00);
            check_eq("t5_second", {24'd0, q_a[1]}, 32'hFF);
            check_eq("t5_third", {24'd0, q_a[2]}, 32'h81);
        end
        check_eq("t5_ferr", {31'd0, ferr_a}, 32'h0);

        // reset in the middle of data bit 4 of 0xC3
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, c3[i]);
        rx = c3[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_dout", {24'd0, dout_a}, 32'h0);
        check_eq("t6_rst_busy", {31'd0, busy_a}, 32'h0);
        check_eq("t6_rst_done", {31'd0, done_a}, 32'h0);
        check_eq("t6_rst_ferr", {31'd0, ferr_a}, 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        check_eq("t6_no_pulse", cnt_a, 6);
        send_frame(8'h12, 0, 0, 1'b0, 1'b1, 2);
        check_eq("t6_count", cnt_a, 7);
        check_eq("t6_dout", {24'd0, dout_a}, 32'h12);
        check_eq("t6_ferr", {31'd0, ferr_a}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
